// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg
// Shared definitions for the PS/2 mouse packet transmitter:
//   - byte0 bit positions of the standard 3-byte mouse packet
//   - device-to-host frame length
//   - packet FSM state encoding
//   - movement saturation bounds and the saturating helper

package ps2_mouse_pkg;

    localparam int FRAME_LEN = 11;  // start + 8 data + parity + stop
    localparam int PKT_BYTES = 3;

    // byte0 bit positions
    localparam int B0_LEFT    = 0;
    localparam int B0_RIGHT   = 1;
    localparam int B0_MIDDLE  = 2;
    localparam int B0_ALWAYS1 = 3;
    localparam int B0_X_SIGN  = 4;
    localparam int B0_Y_SIGN  = 5;
    localparam int B0_X_OVF   = 6;
    localparam int B0_Y_OVF   = 7;

    // Movement is reported as a 9-bit two's complement value.
    localparam logic signed [9:0] SAT_MAX = 10'sd255;
    localparam logic signed [9:0] SAT_MIN = -10'sd256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BIT_HI,
        ST_BIT_LO,
        ST_GAP,
        ST_DONE,
        ST_WAIT_INH
    } state_t;

    typedef struct packed {
        logic       ovf;  // clamping occurred
        logic [8:0] val;  // clamped value; val[8] is the sign
    } sat_t;

    function automatic sat_t saturate(input logic signed [9:0] v);
        sat_t r;
        if (v > SAT_MAX) begin
            r.ovf = 1'b1;
            r.val = SAT_MAX[8:0];
        end else if (v < SAT_MIN) begin
            r.ovf = 1'b1;
            r.val = SAT_MIN[8:0];
        end else begin
            r.ovf = 1'b0;
            r.val = v[8:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_mouse_packet_tx_frame.sv
// ps2_frame_tx
// Single-byte PS/2 device-to-host serializer. On start it sends an 11-bit
// frame (start 0, data LSB first, odd parity, stop 1). Each bit is a HIGH
// clock phase (data changes at its start) followed by a LOW clock phase,
// each HALF_PERIOD cycles long. abort returns both lines high at once.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start           one-cycle request to begin a frame with data_byte
//   data_byte       byte to send, sampled on start
//   abort           cancel the frame in progress; no frame_done
//   clk_out         PS/2 clock line (idles high)
//   data_out        PS/2 data line (idles high)
//   phase_end       current clock phase ends this cycle
//   last_bit        the bit in flight is the stop bit
//   frame_done      last cycle of the stop bit's LOW phase

module ps2_frame_tx
    import ps2_mouse_pkg::*;
#(
    parameter int HALF_PERIOD = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_byte,
    input  logic       abort,
    output logic       clk_out,
    output logic       data_out,
    output logic       phase_end,
    output logic       last_bit,
    output logic       frame_done
);

    localparam int CNT_W = $clog2(HALF_PERIOD + 1);

    logic             active;
    logic             phase_lo;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [9:0]       rest;  // bits still to send after the current one

    assign phase_end  = active && (cnt == CNT_W'(HALF_PERIOD - 1));
    assign last_bit   = (bit_idx == 4'(FRAME_LEN - 1));
    assign frame_done = phase_end && phase_lo && last_bit;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            active   <= 1'b0;
            phase_lo <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            clk_out  <= 1'b1;
            data_out <= 1'b1;
            if (reset) rest <= '1;
        end else if (start) begin
            active   <= 1'b1;
            phase_lo <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            clk_out  <= 1'b1;
            data_out <= 1'b0;  // start bit
            // Odd parity: parity bit is set when the data has an even count of ones.
            rest     <= {1'b1, ~^data_byte, data_byte};
        end else if (active) begin
            if (phase_end) begin
                cnt <= '0;
                if (!phase_lo) begin
                    phase_lo <= 1'b1;
                    clk_out  <= 1'b0;
                end else if (last_bit) begin
                    active   <= 1'b0;
                    phase_lo <= 1'b0;
                    bit_idx  <= '0;
                    clk_out  <= 1'b1;
                    data_out <= 1'b1;
                end else begin
                    phase_lo <= 1'b0;
                    bit_idx  <= bit_idx + 4'd1;
                    clk_out  <= 1'b1;
                    data_out <= rest[0];
                    rest     <= {1'b1, rest[9:1]};
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_packet_tx.sv
// ps2_mouse_packet_tx
// Device-side PS/2 mouse emulator. A send request latches movement and
// buttons, builds the 3-byte mouse packet (with saturation to -256..255)
// and transmits it byte by byte with idle gaps. Host inhibit aborts and
// later restarts the whole packet; inhibit during a gap just pauses it.
// Ports:
//   clk, reset                      system clock, synchronous active-high reset
//   send                            one-cycle packet request (ignored while busy)
//   dx, dy                          signed movement (+right, +up)
//   left_btn, right_btn, middle_btn button states
//   inhibit                         host holding the clock low
//   ps2_clk, ps2_data               PS/2 lines, idle high
//   byte_out                        byte currently / last transmitted
//   byte_valid                      pulse on the first cycle after a stop bit
//   busy                            packet in progress
//   done                            pulse when the packet completes

module ps2_mouse_packet_tx #(
    parameter int HALF_PERIOD = 2000,
    parameter int BYTE_GAP    = 4000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [9:0] dx,
    input  logic [9:0] dy,
    input  logic       left_btn,
    input  logic       right_btn,
    input  logic       middle_btn,
    input  logic       inhibit,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       busy,
    output logic       done
);

    import ps2_mouse_pkg::*;

    localparam int CNT_MAX = (HALF_PERIOD > BYTE_GAP) ? HALF_PERIOD : BYTE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(BYTE_GAP - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [2:0][7:0]  pkt_q;

    sat_t       x_sat, y_sat;
    logic [7:0] byte0;
    logic       accept;

    logic fr_start, fr_abort;
    logic fr_phase_end, fr_last_bit, fr_frame_done;

    assign x_sat  = saturate($signed(dx));
    assign y_sat  = saturate($signed(dy));
    assign accept = (state_q == ST_IDLE) && send && !inhibit;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        byte0              = '0;
        byte0[B0_LEFT]     = left_btn;
        byte0[B0_RIGHT]    = right_btn;
        byte0[B0_MIDDLE]   = middle_btn;
        byte0[B0_ALWAYS1]  = 1'b1;
        byte0[B0_X_SIGN]   = x_sat.val[8];
        byte0[B0_Y_SIGN]   = y_sat.val[8];
        byte0[B0_X_OVF]    = x_sat.ovf;
        byte0[B0_Y_OVF]    = y_sat.ovf;
    end

    // A frame starts only from LOAD; inhibit seen in LOAD aborts before it begins.
    assign fr_start = (state_q == ST_LOAD) && !inhibit;
    // Once the stop bit's LOW phase is reached the byte is allowed to complete.
    assign fr_abort = inhibit &&
                      ((state_q == ST_BIT_HI) || (state_q == ST_BIT_LO && !fr_last_bit));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_LOAD;
                    byte_idx_d = '0;
                end
            end
            ST_LOAD: begin
                if (inhibit) begin
                    state_d = ST_WAIT_INH;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_BIT_HI;
                end
            end
            ST_BIT_HI: begin
                if (fr_abort) begin
                    state_d = ST_WAIT_INH;
                    cnt_d   = '0;
                end else if (fr_phase_end) begin
                    state_d = ST_BIT_LO;
                end
            end
            ST_BIT_LO: begin
                if (fr_abort) begin
                    state_d = ST_WAIT_INH;
                    cnt_d   = '0;
                end else if (fr_frame_done) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else if (fr_phase_end) begin
                    state_d = ST_BIT_HI;
                end
            end
            ST_GAP: begin
                // Inhibit freezes the gap count rather than aborting.
                if (!inhibit) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (byte_idx_q == 2'(PKT_BYTES - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d    = ST_LOAD;
                            byte_idx_d = byte_idx_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT_INH: begin
                // The gap restarts whenever the host re-asserts inhibit.
                if (inhibit) begin
                    cnt_d = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d    = ST_LOAD;
                    byte_idx_d = '0;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            byte_idx_q <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
            byte_valid <= fr_frame_done;
            if (fr_start) byte_out <= pkt_q[byte_idx_q];
        end
    end

    // NOTE: the packet holding register has no reset; it is always written on
    // an accepted send before any byte of it is read.
    always_ff @(posedge clk) begin
        if (accept) pkt_q <= {y_sat.val[7:0], x_sat.val[7:0], byte0};
    end

    assign done = (state_q == ST_DONE);
    assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);

    ps2_frame_tx #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_frame (
        .clk       (clk),
        .reset     (reset),
        .start     (fr_start),
        .data_byte (pkt_q[byte_idx_q]),
        .abort     (fr_abort),
        .clk_out   (ps2_clk),
        .data_out  (ps2_data),
        .phase_end (fr_phase_end),
        .last_bit  (fr_last_bit),
        .frame_done(fr_frame_done)
    );

endmodule

// File: tb/tb_ps2_mouse_packet_tx.sv
// Bench for ps2_mouse_packet_tx with HALF_PERIOD=4, BYTE_GAP=8. A line
// monitor decodes frames from ps2_clk falling edges and records byte_valid
// and done pulses; expected bytes come from a plain-arithmetic packet model.

module tb_ps2_mouse_packet_tx;

    localparam int H = 4;
    localparam int G = 8;
    localparam int PKT_CYCLES = 3 * (22 * H + G) + 3;

    logic       clk, reset, send, inhibit;
    logic       left_btn, right_btn, middle_btn;
    logic [9:0] dx, dy;
    logic       ps2_clk, ps2_data, byte_valid, busy, done;
    logic [7:0] byte_out;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [10:0] frame_q[$];
    logic [7:0]  valid_q[$];
    logic [7:0]  exp_q[$];
    int          done_cnt      = 0;
    int          last_done_cyc = 0;

    ps2_mouse_packet_tx #(
        .HALF_PERIOD(H),
        .BYTE_GAP   (G)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .send      (send),
        .dx        (dx),
        .dy        (dy),
        .left_btn  (left_btn),
        .right_btn (right_btn),
        .middle_btn(middle_btn),
        .inhibit   (inhibit),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Line monitor: host-side view, sampling data on ps2_clk falling edges.
    initial begin
        logic [10:0] acc;
        int          nbits;
        int          hi_run;
        logic        clk_prev;
        acc      = '0;
        nbits    = 0;
        hi_run   = 0;
        clk_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (clk_prev && !ps2_clk) begin
                acc[nbits] = ps2_data;
                nbits++;
                if (nbits == 11) begin
                    frame_q.push_back(acc);
                    nbits = 0;
                end
            end
            hi_run = ps2_clk ? hi_run + 1 : 0;
            if (hi_run > H + 1) nbits = 0;  // idle line discards a partial frame
            clk_prev = ps2_clk;
            if (byte_valid) valid_q.push_back(byte_out);
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    function automatic int clamp_v(int v);
        return (v > 255) ? 255 : ((v < -256) ? -256 : v);
    endfunction

    task automatic model_packet(input int x, input int y, input int l, input int r, input int m);
        int xc, yc, b0;
        xc = clamp_v(x);
        yc = clamp_v(y);
        b0 = l + 2 * r + 4 * m + 8 + ((xc < 0) ? 16 : 0) + ((yc < 0) ? 32 : 0)
           + ((xc != x) ? 64 : 0) + ((yc != y) ? 128 : 0);
        exp_q.delete();
        exp_q.push_back(8'(b0));
        exp_q.push_back(8'(xc));
        exp_q.push_back(8'(yc));
    endtask

    // Called just after a negedge; returns at the negedge after send was sampled.
    task automatic start_packet(input int x, input int y, input int l, input int r,
                                input int m, output int s);
        frame_q.delete();
        valid_q.delete();
        done_cnt   = 0;
        dx         = 10'(x);
        dy         = 10'(y);
        left_btn   = 1'(l);
        right_btn  = 1'(r);
        middle_btn = 1'(m);
        send       = 1'b1;
        @(negedge clk);
        s    = cyc;
        send = 1'b0;
        // Scramble inputs to make sure the packet uses the latched values.
        dx         = 10'($urandom);
        dy         = 10'($urandom);
        left_btn   = 1'($urandom);
        right_btn  = 1'($urandom);
        middle_btn = 1'($urandom);
    endtask

    task automatic wait_packet_end(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 4 * PKT_CYCLES) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (done_cnt == 0) begin
            tests_failed++;
            $display("FAIL %s timeout: done seen %0d times, required 1", tag, done_cnt);
        end
        repeat (G + 4) @(negedge clk);
    endtask

    task automatic check_stream(input string tag);
        logic [10:0] f;
        logic        par;
        tests_run++;
        if (frame_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s frame count: got %0d required %0d", tag, frame_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < frame_q.size(); i++) begin
            f   = frame_q[i];
            par = ($countones(exp_q[i]) % 2 == 0);
            tests_run++;
            if (f[8:1] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL %s frame%0d data: got %02h required %02h", tag, i, f[8:1], exp_q[i]);
            end
            tests_run++;
            if ({f[10], f[9], f[0]} !== {1'b1, par, 1'b0}) begin
                tests_failed++;
                $display("FAIL %s frame%0d stop/parity/start: got %b required %b",
                         tag, i, {f[10], f[9], f[0]}, {1'b1, par, 1'b0});
            end
        end
        tests_run++;
        if (valid_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s byte_valid count: got %0d required %0d", tag, valid_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < valid_q.size(); i++) begin
            tests_run++;
            if (valid_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL %s byte_out%0d: got %02h required %02h", tag, i, valid_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL %s done pulses: got %0d required 1", tag, done_cnt);
        end
        tests_run++;
        if ({busy, ps2_clk, ps2_data} !== 3'b011) begin
            tests_failed++;
            $display("FAIL %s idle after done busy/clk/data: got %b required 011",
                     tag, {busy, ps2_clk, ps2_data});
        end
    endtask

    task automatic check_latency(input string tag, input int s, input int required);
        tests_run++;
        if (last_done_cyc - s !== required) begin
            tests_failed++;
            $display("FAIL %s send-to-done: got %0d required %0d", tag, last_done_cyc - s, required);
        end
    endtask

    task automatic run_packet(input string tag, input int x, input int y,
                              input int l, input int r, input int m);
        int s;
        model_packet(x, y, l, r, m);
        start_packet(x, y, l, r, m, s);
        wait_packet_end(tag);
        check_stream(tag);
        check_latency(tag, s, PKT_CYCLES);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({ps2_clk, ps2_data, busy, done, byte_valid} !== 5'b11000) begin
            tests_failed++;
            $display("FAIL reset clk/data/busy/done/valid: got %b required 11000",
                     {ps2_clk, ps2_data, busy, done, byte_valid});
        end
        tests_run++;
        if (byte_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset byte_out: got %02h required 00", byte_out);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int s;
        model_packet(5, -3, 1, 0, 0);
        start_packet(5, -3, 1, 0, 0, s);
        @(negedge clk);
        tests_run++;
        if ({busy, ps2_clk, ps2_data} !== 3'b110) begin
            tests_failed++;
            $display("FAIL start bit busy/clk/data: got %b required 110", {busy, ps2_clk, ps2_data});
        end
        repeat (H - 1) @(negedge clk);
        tests_run++;
        if (ps2_clk !== 1'b1) begin
            tests_failed++;
            $display("FAIL first high phase ps2_clk: got %b required 1", ps2_clk);
        end
        @(negedge clk);
        tests_run++;
        if (ps2_clk !== 1'b0) begin
            tests_failed++;
            $display("FAIL first falling edge ps2_clk: got %b required 0", ps2_clk);
        end
        wait_packet_end("basic");
        check_stream("basic");
        check_latency("basic", s, PKT_CYCLES);
    endtask

    task automatic test_saturation();
        int tx[4] = '{300, 255, 256, -512};
        int ty[4] = '{-300, -256, -257, 511};
        for (int i = 0; i < 4; i++) run_packet($sformatf("sat%0d", i), tx[i], ty[i], 0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_packet($sformatf("rand%0d", i),
                       int'($urandom_range(0, 800)) - 400, int'($urandom_range(0, 800)) - 400,
                       int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_send_inhibited();
        inhibit = 1'b1;
        send    = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, ps2_clk, ps2_data} !== 3'b011) begin
            tests_failed++;
            $display("FAIL send under inhibit busy/clk/data: got %b required 011",
                     {busy, ps2_clk, ps2_data});
        end
        inhibit = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int s;
        model_packet(-20, 77, 0, 0, 1);
        start_packet(-20, 77, 0, 0, 1, s);
        while (cyc < s + 120) @(negedge clk);
        dx   = 10'd100;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_packet_end("b2b");
        repeat (PKT_CYCLES / 2) @(negedge clk);
        check_stream("b2b");
        check_latency("b2b", s, PKT_CYCLES);
    endtask

    task automatic test_inhibit_abort();
        int   s;
        logic bad;
        logic [7:0] first;
        model_packet(5, -3, 1, 0, 0);
        first = exp_q[0];
        start_packet(5, -3, 1, 0, 0, s);
        while (cyc < s + 130) @(negedge clk);  // byte1, frame bit 4 high phase
        inhibit = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({ps2_clk, ps2_data, busy} !== 3'b111) begin
            tests_failed++;
            $display("FAIL abort clk/data/busy: got %b required 111", {ps2_clk, ps2_data, busy});
        end
        bad = 1'b0;
        repeat (19) begin
            @(negedge clk);
            if (!ps2_clk || !ps2_data || byte_valid) bad = 1'b1;
        end
        inhibit = 1'b0;
        tests_run++;
        if (bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL inhibit hold lines/valid activity: got %b required 0", bad);
        end
        tests_run++;
        if (valid_q.size() != 1) begin
            tests_failed++;
            $display("FAIL byte_valid before resend: got %0d required 1", valid_q.size());
        end
        wait_packet_end("inhibit");
        exp_q.push_front(first);
        check_stream("inhibit");
    endtask

    task automatic test_inhibit_gap();
        int s;
        model_packet(-1, 1, 1, 1, 1);
        start_packet(-1, 1, 1, 1, 1, s);
        while (cyc < s + 90) @(negedge clk);  // inside the gap after byte0
        inhibit = 1'b1;
        repeat (15) @(negedge clk);
        inhibit = 1'b0;
        wait_packet_end("gap_hold");
        check_stream("gap_hold");
        check_latency("gap_hold", s, PKT_CYCLES + 15);
    endtask

    task automatic test_reset_mid();
        int s;
        start_packet(40, 40, 0, 0, 0, s);
        while (cyc < s + 200) @(negedge clk);  // byte2 in flight
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if ({ps2_clk, ps2_data, busy, done} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL mid reset clk/data/busy/done: got %b required 1100",
                     {ps2_clk, ps2_data, busy, done});
        end
        repeat (120) @(negedge clk);
        tests_run++;
        if (done_cnt !== 0) begin
            tests_failed++;
            $display("FAIL mid reset done pulses: got %0d required 0", done_cnt);
        end
        run_packet("after_reset", 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset      = 1'b1;
        send       = 1'b0;
        inhibit    = 1'b0;
        dx         = '0;
        dy         = '0;
        left_btn   = 1'b0;
        right_btn  = 1'b0;
        middle_btn = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        run_packet("zero", 0, 0, 0, 0, 0);
        test_saturation();
        test_random();
        test_send_inhibited();
        test_back_to_back();
        test_inhibit_abort();
        test_inhibit_gap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
